// File: rtl/flux_tempo_autocorr.sv
// rtl/flux_tempo_autocorr.sv - autocorrelation tempo estimator over a circular flux history
// One saturated sample per frame rising edge; best lag reported after every frame once history is full.
module flux_tempo_autocorr #(
   parameter int D       = 16,
   parameter int W_IN    = 70,
   parameter int HIST    = 64,
   parameter int LAG_MIN = 8,
   parameter int LAG_MAX = 32,
   parameter int ACC_W   = 2*D + $clog2(HIST)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flux_valid,
   input  logic [W_IN-1:0]         flux_value,
   output logic [$clog2(HIST)-1:0] best_lag,
   output logic [ACC_W-1:0]        best_score,
   output logic                    tempo_valid,
   output logic                    busy,
   output logic                    dropped
);
   localparam int LW = $clog2(HIST);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_LEND = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam logic [LW-1:0] LAG_MIN_C = LW'(LAG_MIN);
   localparam logic [LW-1:0] LAG_MAX_C = LW'(LAG_MAX);
   localparam logic [LW-1:0] LAST_IDX  = LW'(HIST - 1);
   localparam logic [LW:0]   FULL      = (LW+1)'(HIST);

   logic [1:0]       state;
   logic             fv_q;
   logic             rise;
   logic [D-1:0]     sample;
   logic [D-1:0]     hist [HIST];
   logic [D-1:0]     pend_data;
   logic             pend_valid;
   logic [LW-1:0]    wr_ptr;
   logic [LW:0]      fill;
   logic [LW:0]      fill_next;
   logic [LW-1:0]    lag;
   logic [LW-1:0]    idx;
   logic [LW-1:0]    rd_a;
   logic [LW-1:0]    rd_b;
   logic [2*D-1:0]   prod;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] best_i;
   logic [LW-1:0]    best_lag_i;
   logic             do_commit;
   logic [D-1:0]     commit_data;
   logic             acc_wins;

   assign rise      = flux_valid & ~fv_q;
   assign sample    = (flux_value[W_IN-1:D] == '0) ? flux_value[D-1:0] : '1;
   assign busy      = (state != S_IDLE);
   assign fill_next = (fill == FULL) ? fill : fill + 1'b1;
   // wr_ptr is the oldest entry, so chronological index i lives at wr_ptr+i (wraps in LW bits)
   assign rd_a      = wr_ptr + idx;
   assign rd_b      = wr_ptr + idx + lag;
   assign prod      = hist[rd_a] * hist[rd_b];
   assign acc_wins  = (acc > best_i);

   always_comb begin
      do_commit   = 1'b0;
      commit_data = sample;
      if (state == S_IDLE) begin
         if (pend_valid) begin
            do_commit   = 1'b1;
            commit_data = pend_data;
         end else if (rise) begin
            do_commit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_commit)
         hist[wr_ptr] <= commit_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         fv_q        <= 1'b0;
         pend_data   <= '0;
         pend_valid  <= 1'b0;
         wr_ptr      <= '0;
         fill        <= '0;
         lag         <= '0;
         idx         <= '0;
         acc         <= '0;
         best_i      <= '0;
         best_lag_i  <= '0;
         best_lag    <= '0;
         best_score  <= '0;
         tempo_valid <= 1'b0;
         dropped     <= 1'b0;
      end else begin
         fv_q        <= flux_valid;
         tempo_valid <= 1'b0;
         dropped     <= 1'b0;

         if (do_commit) begin
            wr_ptr <= wr_ptr + 1'b1;
            fill   <= fill_next;
         end

         // A rise coinciding with a pending commit simply refills the pending slot
         if (state == S_IDLE) begin
            if (pend_valid) begin
               if (rise) pend_data  <= sample;
               else      pend_valid <= 1'b0;
            end
         end else if (rise) begin
            pend_data  <= sample;
            pend_valid <= 1'b1;
            dropped    <= pend_valid;
         end

         case (state)
            S_IDLE: begin
               if (do_commit && fill_next == FULL) begin
                  state      <= S_MAC;
                  lag        <= LAG_MIN_C;
                  idx        <= '0;
                  acc        <= '0;
                  best_lag_i <= LAG_MIN_C;
                  best_i     <= '0;
               end
            end
            S_MAC: begin
               acc <= acc + ACC_W'(prod);
               if (idx == LAST_IDX - lag) state <= S_LEND;
               else                       idx   <= idx + 1'b1;
            end
            S_LEND: begin
               if (acc_wins) begin
                  best_i     <= acc;
                  best_lag_i <= lag;
               end
               if (lag == LAG_MAX_C) begin
                  state       <= S_DONE;
                  best_lag    <= acc_wins ? lag : best_lag_i;
                  best_score  <= acc_wins ? acc : best_i;
                  tempo_valid <= 1'b1;
               end else begin
                  lag   <= lag + 1'b1;
                  idx   <= '0;
                  acc   <= '0;
                  state <= S_MAC;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
